// File: rtl/traffic_light_monitor.sv
// Watches four traffic lamps for illegal encodings, conflicting greens/yellows,
// bad colour sequences and dwell-time violations; latches the first fault seen.
module traffic_light_monitor #(
    parameter int YEL_MIN = 3,
    parameter int YEL_MAX = 5,
    parameter int GRN_MIN = 3,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  light_M1,
    input  logic [2:0]  light_S,
    input  logic [2:0]  light_M2,
    input  logic [2:0]  light_MT,
    input  logic        en,
    input  logic        clr,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [1:0]  fault_light,
    output logic [15:0] cycle_count,
    output logic        all_red
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] YEL_MIN_C = CNT_W'(YEL_MIN);
    localparam logic [CNT_W-1:0] YEL_MAX_C = CNT_W'(YEL_MAX);
    localparam logic [CNT_W-1:0] GRN_MIN_C = CNT_W'(GRN_MIN);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic is_legal(input logic [2:0] v);
        return (v == RED) || (v == YEL) || (v == GRN);
    endfunction

    // Lamp index order: M1=0, S=1, M2=2, MT=3
    logic [2:0]       cur   [4];
    logic [2:0]       prev  [4];
    logic [CNT_W-1:0] dwell [4];
    logic [3:0]       act;
    logic [3:0]       det   [7];
    logic             det_any;
    logic [2:0]       det_code;
    logic [1:0]       det_light;

    assign cur[0] = light_M1;
    assign cur[1] = light_S;
    assign cur[2] = light_M2;
    assign cur[3] = light_MT;

    always_comb begin
        for (int c = 0; c < 7; c++) det[c] = 4'b0000;
        act = 4'b0000;
        for (int l = 0; l < 4; l++) begin
            act[l]    = cur[l][1] | cur[l][0];
            det[1][l] = !is_legal(cur[l]);
            if (is_legal(cur[l]) && is_legal(prev[l])) begin
                det[3][l] = ((prev[l] == GRN) && (cur[l] == RED)) ||
                            ((prev[l] == RED) && (cur[l] == YEL)) ||
                            ((prev[l] == YEL) && (cur[l] == GRN));
            end
            det[4][l] = (prev[l] == YEL) && (cur[l] == RED) && (dwell[l] < YEL_MIN_C);
            det[5][l] = (prev[l] == YEL) && (cur[l] == YEL) && (dwell[l] >= YEL_MAX_C);
            det[6][l] = (prev[l] == GRN) && (cur[l] == YEL) && (dwell[l] < GRN_MIN_C);
        end
        // Conflict is reported against the lower lamp index of the pair
        det[2][0] = act[1] & act[0];
        det[2][1] = (act[1] & act[2]) | (act[1] & act[3]);
        det[2][2] = act[3] & act[2];
    end

    // Scan from highest to lowest so the lowest code, then lowest lamp, wins
    always_comb begin
        det_any   = 1'b0;
        det_code  = 3'd0;
        det_light = 2'd0;
        for (int c = 6; c >= 0; c--) begin
            for (int l = 3; l >= 0; l--) begin
                if (det[c][l]) begin
                    det_any   = 1'b1;
                    det_code  = 3'(c);
                    det_light = 2'(l);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            fault_light <= 2'd0;
            cycle_count <= 16'd0;
            all_red     <= 1'b0;
            for (int l = 0; l < 4; l++) begin
                prev[l]  <= RED;
                dwell[l] <= CNT_ONE;
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                prev[l]  <= cur[l];
                dwell[l] <= (cur[l] != prev[l]) ? CNT_ONE : sat_inc(dwell[l]);
            end
            all_red <= (cur[0] == RED) && (cur[1] == RED) &&
                       (cur[2] == RED) && (cur[3] == RED);
            // A same-cycle detection takes precedence over clr
            if (en && det_any && (!fault || clr)) begin
                fault       <= 1'b1;
                fault_code  <= det_code;
                fault_light <= det_light;
            end else if (clr) begin
                fault       <= 1'b0;
                fault_code  <= 3'd0;
                fault_light <= 2'd0;
            end
            if (en && (prev[0] == RED) && (cur[0] == GRN))
                cycle_count <= cycle_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed-vector bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  light_M1, light_S, light_M2, light_MT;
    logic        en, clr;
    logic        fault;
    logic [2:0]  fault_code;
    logic [1:0]  fault_light;
    logic [15:0] cycle_count;
    logic        all_red;

    int checks   = 0;
    int failures = 0;

    traffic_light_monitor dut (
        .clk(clk), .rst(rst),
        .light_M1(light_M1), .light_S(light_S), .light_M2(light_M2), .light_MT(light_MT),
        .en(en), .clr(clr),
        .fault(fault), .fault_code(fault_code), .fault_light(fault_light),
        .cycle_count(cycle_count), .all_red(all_red)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] m1, input logic [2:0] s,
                        input logic [2:0] m2, input logic [2:0] mt);
        light_M1 = m1;
        light_S  = s;
        light_M2 = m2;
        light_MT = mt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr = 1'b0;
        en  = 1'b1;
        step(R, R, R, R);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; clr = 1'b0;
        light_M1 = R; light_S = R; light_M2 = R; light_MT = R;
        step(R, R, R, R);
        step(R, R, R, R);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        chk("rst_light", fault_light, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_allred", all_red, 0);
        rst = 1'b1;
        step(R, R, R, R);
        chk("allred_set", all_red, 1);

        // Legal run: two M1 red->green transitions
        for (int i = 0; i < 4; i++) step(G, R, R, R);
        chk("legal_count1", cycle_count, 1);
        chk("legal_allred0", all_red, 0);
        for (int i = 0; i < 3; i++) step(Y, R, R, R);
        step(R, R, R, R);
        for (int i = 0; i < 4; i++) step(R, G, R, R);
        for (int i = 0; i < 3; i++) step(R, Y, R, R);
        step(R, R, R, R);
        chk("legal_fault_mid", fault, 0);
        step(G, R, R, R);
        chk("legal_fault", fault, 0);
        chk("legal_count2", cycle_count, 2);

        // S and M2 green together
        do_reset();
        step(R, G, G, R);
        chk("conf_fault", fault, 1);
        chk("conf_code", fault_code, 2);
        chk("conf_light", fault_light, 1);

        // G->R illegal transition, then sticky against MT faults
        do_reset();
        for (int i = 0; i < 4; i++) step(G, R, R, R);
        chk("gr_nofault", fault, 0);
        step(R, R, R, R);
        chk("gr_code", fault_code, 3);
        chk("gr_light", fault_light, 0);
        for (int i = 0; i < 6; i++) step(R, R, R, Y);
        chk("sticky_code", fault_code, 3);
        chk("sticky_light", fault_light, 0);

        // MT yellow long, then yellow short
        do_reset();
        for (int i = 0; i < 3; i++) step(R, R, R, G);
        for (int i = 0; i < 5; i++) step(R, R, R, Y);
        chk("ylong_5th", fault, 0);
        step(R, R, R, Y);
        chk("ylong_fault", fault, 1);
        chk("ylong_code", fault_code, 5);
        chk("ylong_light", fault_light, 3);
        clr = 1'b1;
        step(R, R, R, R);
        clr = 1'b0;
        chk("clr_clears", fault, 0);
        for (int i = 0; i < 3; i++) step(R, R, R, G);
        step(R, R, R, Y);
        step(R, R, R, Y);
        chk("yshort_pre", fault, 0);
        step(R, R, R, R);
        chk("yshort_code", fault_code, 4);
        chk("yshort_light", fault_light, 3);

        // Green short on M2
        do_reset();
        step(R, R, G, R);
        step(R, R, G, R);
        step(R, R, Y, R);
        chk("gshort_code", fault_code, 6);
        chk("gshort_light", fault_light, 2);

        // Illegal encoding beats conflict; clr behaviour
        do_reset();
        step(G, 3'b011, R, R);
        chk("illeg_code", fault_code, 1);
        chk("illeg_light", fault_light, 1);
        clr = 1'b1;
        step(G, R, R, R);
        clr = 1'b0;
        chk("clr_nodet", fault, 0);
        step(G, R, 3'b000, R);
        chk("m2_illeg_code", fault_code, 1);
        chk("m2_illeg_light", fault_light, 2);
        clr = 1'b1;
        step(G, G, R, R);
        clr = 1'b0;
        chk("clr_det_fault", fault, 1);
        chk("clr_det_code", fault_code, 2);
        chk("clr_det_light", fault_light, 0);

        // Enable low: no detection, no counting, tracking continues
        do_reset();
        en = 1'b0;
        step(G, R, R, R);
        step(R, R, R, R);
        chk("en0_fault", fault, 0);
        chk("en0_count", cycle_count, 0);
        en = 1'b1;
        step(G, R, R, R);
        chk("en1_count", cycle_count, 1);
        chk("en1_fault", fault, 0);

        // Five cycles, a fault, then reset overrides everything
        do_reset();
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 3; i++) step(G, R, R, R);
            for (int i = 0; i < 3; i++) step(Y, R, R, R);
            step(R, R, R, R);
        end
        chk("five_count", cycle_count, 5);
        step(R, 3'b000, R, R);
        chk("pre_rst_fault", fault, 1);
        rst = 1'b0;
        clr = 1'b0;
        step(R, 3'b000, R, R);
        chk("rst2_fault", fault, 0);
        chk("rst2_code", fault_code, 0);
        chk("rst2_count", cycle_count, 0);
        chk("rst2_allred", all_red, 0);
        rst = 1'b1;
        step(Y, R, R, R);
        chk("post_rst_code", fault_code, 3);
        chk("post_rst_light", fault_light, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
